// File: rtl/cla_accumulator.sv
// ----------------------------------------------------------------------------
// cla_accumulator
//
// Purpose:
//    Streaming accumulator that sums a burst of 32-bit operands using a single
//    two-level carry-lookahead adder (acc + operand, carry-in tied to 0). The
//    burst total, a sticky carry flag, the beat count and a truncation flag are
//    presented on a valid/ready output once the burst closes.
//
// Ports (top):
//    clk        in   1      clock, all state changes on the rising edge
//    rst        in   1      synchronous reset, active high
//    in_valid   in   1      operand beat valid
//    in_ready   out  1      operand can be accepted this cycle
//    in_data    in   32     operand
//    in_last    in   1      beat is the final operand of the burst
//    out_valid  out  1      result valid
//    out_ready  in   1      consumer takes the result this cycle
//    out_sum    out  32     accumulated sum
//    out_carry  out  1      sticky: some add in the burst carried out
//    out_count  out  CNT_W  number of beats accepted in the burst
//    out_trunc  out  1      burst closed by the beat-count limit, not in_last
//
// Parameter:
//    CNT_W      beat counter width; a burst closes after 2**CNT_W-1 beats
//
// Build option:
//    ACC_SATURATE_EN  when defined, any add that carries out pins the
//                     accumulator at 32'hFFFF_FFFF instead of wrapping.
// ----------------------------------------------------------------------------

// Four-position lookahead carry unit. Used both on raw bit propagate/generate
// pairs and on group propagate/generate pairs, giving a two-level tree.
module ClaLookahead4 (
    input  logic [3:0] i_p,
    input  logic [3:0] i_g,
    input  logic       i_cin,
    output logic [3:0] o_c,
    output logic       o_p,
    output logic       o_g
);
    // Carries are fully expanded so no position waits on its neighbour.
    assign o_c[0] = i_cin;
    assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

    // Group terms feed the next lookahead level.
    assign o_p = &i_p;
    assign o_g = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
               | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
endmodule

// 32-bit carry-lookahead adder: eight 4-bit groups, two 16-bit supergroups,
// and a final two-way lookahead for the supergroup carries and carry-out.
module CLA_32bit_Adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [31:0] w_c;
    logic [7:0]  w_grpP;
    logic [7:0]  w_grpG;
    logic [7:0]  w_grpC;
    logic [1:0]  w_supP;
    logic [1:0]  w_supG;
    logic [1:0]  w_supC;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Bit level: each unit turns its group carry-in into per-bit carries.
    for (genvar k = 0; k < 8; k++) begin : g_bitLevel
        ClaLookahead4 u_bitLa (
            .i_p   (w_p[4*k +: 4]),
            .i_g   (w_g[4*k +: 4]),
            .i_cin (w_grpC[k]),
            .o_c   (w_c[4*k +: 4]),
            .o_p   (w_grpP[k]),
            .o_g   (w_grpG[k])
        );
    end

    // Group level: each unit produces the carries into four 4-bit groups.
    for (genvar j = 0; j < 2; j++) begin : g_grpLevel
        ClaLookahead4 u_grpLa (
            .i_p   (w_grpP[4*j +: 4]),
            .i_g   (w_grpG[4*j +: 4]),
            .i_cin (w_supC[j]),
            .o_c   (w_grpC[4*j +: 4]),
            .o_p   (w_supP[j]),
            .o_g   (w_supG[j])
        );
    end

    // Top level only has two supergroups, so it is written out directly.
    assign w_supC[0] = i_cin;
    assign w_supC[1] = w_supG[0] | (w_supP[0] & i_cin);
    assign o_cout    = w_supG[1] | (w_supP[1] & w_supG[0])
                     | (w_supP[1] & w_supP[0] & i_cin);

    assign o_sum = w_p ^ w_c;
endmodule

module cla_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_COUNT = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_stateNext;
    logic [31:0]      r_acc;
    logic [31:0]      w_accNext;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_countNext;
    logic             r_carry;
    logic             w_carryNext;
    logic             r_trunc;
    logic             w_truncNext;

    logic [31:0]      w_sum;
    logic             w_cout;
    logic [31:0]      w_addResult;
    logic             w_accept;

    // The single adder always sees the live accumulator and the incoming
    // operand; the FSM decides whether its result is kept.
    CLA_32bit_Adder u_adder (
        .i_a    (r_acc),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef ACC_SATURATE_EN
    // Once pinned at all-ones, any further nonzero operand carries out again,
    // so the accumulator stays pinned for the rest of the burst.
    assign w_addResult = w_cout ? 32'hFFFF_FFFF : w_sum;
`else
    assign w_addResult = w_sum;
`endif

    // Ready is withheld during reset and while a result waits to be taken.
    assign in_ready  = !rst && (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;

    assign out_sum   = r_acc;
    assign out_carry = r_carry;
    assign out_count = r_count;
    assign out_trunc = r_trunc;

    // Next-state and datapath selection. The first beat loads the operand
    // directly; the count limit is checked on the updated count so that a
    // burst of exactly MAX_COUNT beats closes on its final beat.
    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_countNext = r_count;
        w_carryNext = r_carry;
        w_truncNext = r_trunc;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_accNext   = in_data;
                    w_countNext = CNT_W'(1);
                    w_carryNext = 1'b0;
                    w_truncNext = 1'b0;
                    if (in_last) begin
                        w_stateNext = ST_DONE;
                    end else if (CNT_W'(1) == MAX_COUNT) begin
                        w_stateNext = ST_DONE;
                        w_truncNext = 1'b1;
                    end else begin
                        w_stateNext = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_accNext   = w_addResult;
                    w_countNext = r_count + CNT_W'(1);
                    w_carryNext = r_carry | w_cout;
                    if (in_last) begin
                        w_stateNext = ST_DONE;
                    end else if (w_countNext == MAX_COUNT) begin
                        w_stateNext = ST_DONE;
                        w_truncNext = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_stateNext = ST_IDLE;
                    w_accNext   = '0;
                    w_countNext = '0;
                    w_carryNext = 1'b0;
                    w_truncNext = 1'b0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_accNext   = '0;
                w_countNext = '0;
                w_carryNext = 1'b0;
                w_truncNext = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any partial or pending burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_acc   <= w_accNext;
            r_count <= w_countNext;
            r_carry <= w_carryNext;
            r_trunc <= w_truncNext;
        end
    end
endmodule

// File: tb/tb_cla_accumulator.sv
// ----------------------------------------------------------------------------
// tb_cla_accumulator
//
// Purpose:
//    Self-checking bench for cla_accumulator. A burst-level reference model
//    (full-precision running total plus beat count) predicts every output
//    each cycle; directed bursts pin the model with hand-computed literals,
//    then randomized traffic with resets and backpressure exercises the rest.
//
// Build option:
//    ACC_SATURATE_EN  must match the RTL build; selects saturating expectations.
// ----------------------------------------------------------------------------
module tb_cla_accumulator;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    int total = 0;
    int bad   = 0;

    cla_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a burst is just a list of accepted operands. Its exact
    // total decides both the reported sum and whether any add carried out.
    bit              mPending = 1'b0;
    longint unsigned mTotal   = 0;
    int              mCount   = 0;
    bit              mTrunc   = 1'b0;
    bit              modelLive = 1'b0;

    always @(posedge clk) begin
        modelLive = 1'b1;
        if (rst) begin
            mPending = 1'b0;
            mTotal   = 0;
            mCount   = 0;
            mTrunc   = 1'b0;
        end else if (mPending) begin
            if (out_ready) begin
                mPending = 1'b0;
                mTotal   = 0;
                mCount   = 0;
                mTrunc   = 1'b0;
            end
        end else if (in_valid) begin
            mTotal = mTotal + 64'(in_data);
            mCount = mCount + 1;
            if (in_last || mCount == MAXC) begin
                mPending = 1'b1;
                mTrunc   = !in_last;
            end
        end
    end

    function automatic logic [31:0] expSum();
`ifdef ACC_SATURATE_EN
        return (mTotal >= 64'h1_0000_0000) ? 32'hFFFF_FFFF : mTotal[31:0];
`else
        return mTotal[31:0];
`endif
    endfunction

    // Single comparison point shared by the per-cycle checker and directed tests.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("in_ready", 64'(in_ready), 64'(!rst && !mPending));
            checkOutput("out_valid", 64'(out_valid), 64'(mPending));
            if (mPending) begin
                checkOutput("out_sum", 64'(out_sum), 64'(expSum()));
                checkOutput("out_count", 64'(out_count), 64'(mCount));
                checkOutput("out_carry", 64'(out_carry),
                            64'(mTotal >= 64'h1_0000_0000));
                checkOutput("out_trunc", 64'(out_trunc), 64'(mTrunc));
            end
        end
    end

    // Drive one cycle of inputs, then return shortly after the capturing edge.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit l,
                                 input bit ordy, input bit r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_count", 64'(out_count), 64'd0);
        checkOutput("rst_sum", 64'(out_sum), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

        // Single beat
        applyStimulus(1, 32'd999, 1, 0, 0);
        checkOutput("t1_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_sum", 64'(out_sum), 64'd999);
        checkOutput("t1_count", 64'(out_count), 64'd1);
        checkOutput("t1_carry", 64'(out_carry), 64'd0);
        checkOutput("t1_trunc", 64'(out_trunc), 64'd0);
        applyStimulus(0, 0, 0, 1, 0);

        // Two beats with an idle gap
        applyStimulus(1, 32'd45836, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_gap_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 32'd34673, 1, 0, 0);
        checkOutput("t2_sum", 64'(out_sum), 64'h13A7D);
        checkOutput("t2_count", 64'(out_count), 64'd2);
        applyStimulus(0, 0, 0, 1, 0);

        // Wrap / saturate
        applyStimulus(1, 32'hFFFF_FFF0, 0, 0, 0);
        applyStimulus(1, 32'h0000_0020, 1, 0, 0);
`ifdef ACC_SATURATE_EN
        checkOutput("t3_sum", 64'(out_sum), 64'hFFFF_FFFF);
`else
        checkOutput("t3_sum", 64'(out_sum), 64'h10);
`endif
        checkOutput("t3_carry", 64'(out_carry), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);

        // Backpressure: result held, extra operands offered but not taken
        applyStimulus(1, 32'h0E14, 0, 0, 0);
        applyStimulus(1, 32'hAE23, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h5555, 0, 0, 0);
            checkOutput("t4_hold_sum", 64'(out_sum), 64'hBC37);
            checkOutput("t4_hold_ready", 64'(in_ready), 64'd0);
            checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t4_release_ready", 64'(in_ready), 64'd1);
        checkOutput("t4_release_valid", 64'(out_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);

        // Count limit: MAXC beats of 1, never in_last
        for (int i = 0; i < MAXC; i++) begin
            if (i == MAXC - 1)
                checkOutput("t5_not_yet", 64'(out_valid), 64'd0);
            applyStimulus(1, 32'd1, 0, 0, 0);
        end
        checkOutput("t5_valid", 64'(out_valid), 64'd1);
        checkOutput("t5_sum", 64'(out_sum), 64'(MAXC));
        checkOutput("t5_count", 64'(out_count), 64'(MAXC));
        checkOutput("t5_trunc", 64'(out_trunc), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);

        // Reset mid-burst, then a fresh burst
        applyStimulus(1, 32'd5, 0, 0, 0);
        applyStimulus(1, 32'd6, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_idle_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 32'd7, 1, 0, 0);
        checkOutput("t6_sum", 64'(out_sum), 64'd7);
        checkOutput("t6_count", 64'(out_count), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);

        // Randomized traffic with gaps, backpressure and occasional resets
        for (int i = 0; i < 800; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 2))
                0:       d = 32'($urandom_range(0, 255));
                1:       d = $urandom();
                default: d = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            endcase
            applyStimulus(($urandom_range(0, 9) < 7), d,
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 59) == 0));
        end

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
